// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   scan_state_t : scan FSM states
//   SEG_DARK     : cathode pattern with every segment off (active-low)
//   an_dark()    : anode pattern with every digit off for a given digit count
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam logic [7:0] SEG_DARK = 8'hFF;

  // Returns n ones in the low bits; the caller keeps the low NUM_DIGITS bits.
  function automatic logic [63:0] an_dark(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_controller_counter.sv
// scan_tick_counter: loadable down-counter with terminal-count flag.
//   clk, rst     : clock, async active-high reset
//   clr_i        : synchronous clear to 0
//   load_i       : load load_val_i (wins over counting)
//   load_val_i   : value loaded, i.e. period-1
//   tc_o         : high while the count is 0 (last cycle of the period)
module scan_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (clr_i)         cnt_q <= '0;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: time-multiplexed scan of a NUM_DIGITS seven-segment
// display with blanking gaps and frame-synchronous content update.
//   clk, rst    : clock, async active-high reset
//   enable      : 1 = scan, 0 = dark
//   seg_in      : 8 bits per digit, digit 0 in [7:0], active-high, bit7 = dp
//   seg_valid   : seg_in valid
//   seg_ready   : pending buffer empty
//   an          : anode enables, active-low
//   seg_out     : cathodes {dp,g..a}, active-low
//   frame_done  : one-cycle pulse on the first dark cycle after the last digit
module seven_seg_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg_out,
  output logic                    frame_done
);

  localparam int MAXT = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [63:0]           AN_DARK_W = an_dark(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_DARK   = AN_DARK_W[NUM_DIGITS-1:0];

  localparam logic [CW-1:0] DRIVE_LD = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  // With no blanking, every digit transition goes straight to DRIVE.
  localparam scan_state_t    GAP_ST = (BLANK_TICKS == 0) ? DRIVE : BLANK;
  localparam logic [CW-1:0]  GAP_LD = (BLANK_TICKS == 0) ? DRIVE_LD : BLANK_LD;

  scan_state_t             state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    fd_pre_q, fd_pre_d;
  logic [8*NUM_DIGITS-1:0] pend_q, shadow_q;
  logic                    pend_full_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic                    fd_q;

  logic          cnt_clr, cnt_ld, cnt_tc, boundary, accept;
  logic [CW-1:0] cnt_ld_val;

  scan_tick_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_ld),
    .load_val_i (cnt_ld_val),
    .tc_o       (cnt_tc)
  );

  // Next-state decisions; the counter reload must be known in the same cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fd_pre_d   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = DRIVE_LD;
    boundary   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = GAP_ST;
          idx_d      = '0;
          cnt_ld     = 1'b1;
          cnt_ld_val = GAP_LD;
          boundary   = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d    = DRIVE;
          cnt_ld     = 1'b1;
          cnt_ld_val = DRIVE_LD;
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d    = GAP_ST;
          cnt_ld     = 1'b1;
          cnt_ld_val = GAP_LD;
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
            boundary = 1'b1;
            fd_pre_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Output patterns from the current state; enable gates DRIVE so the
  // display goes dark on the same edge the FSM drops to IDLE.
  always_comb begin
    an_d  = AN_DARK;
    seg_d = SEG_DARK;
    if (state_q == DRIVE && enable) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (i == int'(idx_q)) an_d[i] = 1'b0;
      seg_d = ~shadow_q[8*idx_q +: 8];
    end
  end

  assign accept = seg_valid && !pend_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      fd_pre_q <= 1'b0;
      an_q     <= AN_DARK;
      seg_q    <= SEG_DARK;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fd_pre_q <= fd_pre_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fd_q     <= fd_pre_q;
    end
  end

  // Single-entry pending buffer. Accept only happens when empty, so an accept
  // on a boundary edge leaves shadow untouched and the word waits a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      shadow_q    <= '0;
    end else begin
      if (boundary && pend_full_q) shadow_q <= pend_q;
      if (accept) begin
        pend_q      <= seg_in;
        pend_full_q <= 1'b1;
      end else if (boundary && pend_full_q) begin
        pend_full_q <= 1'b0;
      end
    end
  end

  assign seg_ready  = !pend_full_q;
  assign an         = an_q;
  assign seg_out    = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
module tb_seven_seg_scan_controller;

  localparam int ND = 8;

  logic          clk, rst, enable, seg_valid;
  logic [63:0]   seg_in;
  logic          seg_ready, frame_done;
  logic [ND-1:0] an;
  logic [7:0]    seg_out;

  int          tests = 0;
  int          fails = 0;
  int          n = 0;
  bit          model_on = 1'b0;
  logic [63:0] exp_sh = '0;

  localparam logic [63:0] W1 = 64'h6F7F077D6D664F06;
  localparam logic [63:0] WB = 64'h0123456789ABCDEF;
  localparam logic [63:0] WC = 64'hFEDCBA9876543210;
  localparam logic [63:0] WD = 64'h00FF00FF00FF00FF;
  localparam logic [63:0] WE = 64'h8040201008040201;

  seven_seg_scan_controller #(
    .NUM_DIGITS(ND), .TICKS_PER_DIGIT(4), .BLANK_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .seg_in(seg_in),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .an(an),
    .seg_out(seg_out), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at n=%0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // Cycle n counts edges since the enabling edge (n=0). Each digit slot is
  // 6 cycles: 2 dark then 4 driven; a frame is 48 cycles.
  task automatic step();
    int p, d;
    logic [7:0] ea, es;
    @(posedge clk); #1;
    n++;
    if (model_on) begin
      p  = (n - 1) % 6;
      d  = ((n - 1) / 6) % 8;
      ea = 8'hFF;
      es = 8'hFF;
      if (n >= 1 && p >= 2) begin
        ea = ~(8'd1 << d);
        es = ~exp_sh[8*d +: 8];
      end
      chk("an", {56'd0, an}, {56'd0, ea});
      chk("seg_out", {56'd0, seg_out}, {56'd0, es});
      chk("frame_done", {63'd0, frame_done}, {63'd0, (n > 1 && n % 48 == 1)});
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; seg_valid = 1'b0; seg_in = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_an", {56'd0, an}, 64'hFF);
    chk("rst_seg", {56'd0, seg_out}, 64'hFF);
    chk("rst_fd", {63'd0, frame_done}, 64'd0);
    chk("rst_ready", {63'd0, seg_ready}, 64'd1);

    // Load first word while idle; enabling edge copies it to shadow.
    seg_valid = 1'b1; seg_in = W1;
    step();
    chk("load_ready", {63'd0, seg_ready}, 64'd0);
    seg_valid = 1'b0;
    exp_sh = W1; enable = 1'b1; n = -1; model_on = 1'b1;
    step();
    chk("copy_ready", {63'd0, seg_ready}, 64'd1);
    while (n < 3) step();
    chk("d0_W1", {56'd0, seg_out}, 64'hF9);

    // Mid-frame word B, then C offered while B is pending.
    while (n < 10) step();
    seg_valid = 1'b1; seg_in = WB;
    step();
    chk("B_ready", {63'd0, seg_ready}, 64'd0);
    seg_in = WC;
    while (n < 45) step();
    chk("d7_an", {56'd0, an}, 64'h7F);
    chk("d7_W1", {56'd0, seg_out}, 64'h90);
    while (n < 47) step();
    chk("full_ready", {63'd0, seg_ready}, 64'd0);
    step();
    chk("bnd_ready", {63'd0, seg_ready}, 64'd1);
    exp_sh = WB;
    step();
    chk("C_ready", {63'd0, seg_ready}, 64'd0);
    seg_valid = 1'b0;
    while (n < 96) step();
    exp_sh = WC;

    // Accept on the boundary edge with pending empty: shown a frame later.
    while (n < 143) step();
    seg_valid = 1'b1; seg_in = WD;
    step();
    chk("D_ready", {63'd0, seg_ready}, 64'd0);
    seg_valid = 1'b0;
    while (n < 192) step();
    exp_sh = WD;
    while (n < 262) step();
    chk("d3_an", {56'd0, an}, 64'hF7);

    // Drop enable during digit 3.
    enable = 1'b0; model_on = 1'b0;
    step();
    chk("off_an", {56'd0, an}, 64'hFF);
    chk("off_seg", {56'd0, seg_out}, 64'hFF);
    seg_valid = 1'b1; seg_in = WE;
    step();
    chk("idle_ready", {63'd0, seg_ready}, 64'd0);
    seg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("idle_an", {56'd0, an}, 64'hFF);
      chk("idle_fd", {63'd0, frame_done}, 64'd0);
    end

    // Re-enable: restarts at BLANK, digit 0, with the word loaded in IDLE.
    exp_sh = WE; enable = 1'b1; n = -1; model_on = 1'b1;
    step();
    chk("re_ready", {63'd0, seg_ready}, 64'd1);
    while (n < 10) step();
    chk("d1_an", {56'd0, an}, 64'hFD);

    // Asynchronous reset mid-DRIVE.
    rst = 1'b1; model_on = 1'b0;
    #1;
    chk("arst_an", {56'd0, an}, 64'hFF);
    chk("arst_seg", {56'd0, seg_out}, 64'hFF);
    chk("arst_ready", {63'd0, seg_ready}, 64'd1);
    step();
    step();
    rst = 1'b0; exp_sh = '0; n = -1; model_on = 1'b1;
    while (n < 8) step();
    chk("post_rst_seg", {56'd0, seg_out}, 64'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
